// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller for the ALU shift path.
// The shift amount is decomposed into power-of-two stages (1, 2, 4, 8, 16).
// One stage is applied per clock to an internal accumulator.
// Valid/ready handshakes are used on both sides, with one operation in flight.
module shift_sequencer #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = 5,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int K_W = $clog2(SHAMT_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] shamt_q;
  op_t                op_q;
  logic               sign_q;
  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_valid_q;

  logic               accept;
  logic               zero_shortcut;
  logic               stage_bit;
  logic               higher_set;
  logic               last_stage;
  logic [WIDTH-1:0]   stage_val;

  // One candidate result per stage; each one is a fixed rewiring of acc by 2^g.
  logic [SHAMT_W-1:0][WIDTH-1:0] shifted;

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    localparam int D = 1 << g;
    logic [WIDTH-1:0] sll_v;
    logic [WIDTH-1:0] srl_v;
    logic [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0] rol_v;

    assign sll_v = {acc[WIDTH-1-D:0], {D{1'b0}}};
    assign srl_v = {{D{1'b0}}, acc[WIDTH-1:D]};
    assign sra_v = {{D{sign_q}}, acc[WIDTH-1:D]};
    assign rol_v = {acc[WIDTH-1-D:0], acc[WIDTH-1:WIDTH-D]};

    // Pick the fill/wrap flavour of this stage according to the latched operation.
    always_comb begin
      unique case (op_q)
        OP_SLL:  shifted[g] = sll_v;
        OP_SRL:  shifted[g] = srl_v;
        OP_SRA:  shifted[g] = sra_v;
        OP_ROL:  shifted[g] = rol_v;
        default: shifted[g] = sll_v;
      endcase
    end
  end

  assign in_ready      = (state == S_IDLE) & reset;
  assign accept        = in_valid & in_ready;
  assign zero_shortcut = EARLY_EXIT && (in_shamt == '0);
  assign busy          = (state == S_SHIFT) || (state == S_DONE);
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;

  // Select the current stage, and find out whether any higher shamt bit is still set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stage_bit  = 1'b0;
    stage_val  = acc;
    higher_set = 1'b0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (k == K_W'(i)) begin
        stage_bit = shamt_q[i];
      end
      if ((K_W'(i) > k) && shamt_q[i]) begin
        higher_set = 1'b1;
      end
    end
    for (int i = 0; i < SHAMT_W; i++) begin
      if ((k == K_W'(i)) && stage_bit) begin
        stage_val = shifted[i];
      end
    end
  end

  assign last_stage = (k == K_W'(SHAMT_W - 1)) || (EARLY_EXIT && !higher_set);

  // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = zero_shortcut ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_stage) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register; reset is synchronous and active-low.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: capture the request, step the accumulator, and publish the result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc         <= '0;
      shamt_q     <= '0;
      op_q        <= OP_SLL;
      sign_q      <= 1'b0;
      k           <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_next == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            acc     <= in_data;
            shamt_q <= in_shamt;
            op_q    <= op_t'(in_op);
            sign_q  <= in_data[WIDTH-1];
            k       <= '0;
            if (zero_shortcut) begin
              out_data_q <= in_data;
            end
          end
        end
        S_SHIFT: begin
          acc <= stage_val;
          k   <= k + K_W'(1);
          if (last_stage) begin
            out_data_q <= stage_val;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer.
// Two instances are used: early exit on (index 0) and early exit off (index 1).
// A transaction-level model predicts the outputs, and a compare process checks them every cycle.
// Directed operations pin results and latencies to hand-computed values.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        in_valid  [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [31:0] out_data  [2];

  int tests;
  int fails;

  // Model state per instance: 0 idle, 1 working, 2 result available.
  int          m_phase [2];
  int          m_left  [2];
  logic [31:0] m_res   [2];
  logic [31:0] m_out   [2];

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .EARLY_EXIT(1'b1)) u_ee (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
  );

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .EARLY_EXIT(1'b0)) u_full (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d,
                                             input logic [4:0] s);
    logic [63:0] t;
    case (op)
      2'b00:   ref_result = d << s;
      2'b01:   ref_result = d >> s;
      2'b10:   ref_result = $signed(d) >>> s;
      default: begin
        t = {d, d} << s;
        ref_result = t[63:32];
      end
    endcase
  endfunction

  // Edges from the accept edge (counted as 1) until out_valid is seen high.
  function automatic int ref_lat(input int inst, input logic [4:0] s);
    int msb;
    msb = -1;
    for (int b = 0; b < 5; b++) begin
      if (s[b]) msb = b;
    end
    if (inst == 1) ref_lat = 6;
    else if (msb < 0) ref_lat = 1;
    else ref_lat = msb + 2;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_left[i]  = 0;
      m_res[i]   = '0;
      m_out[i]   = '0;
    end
  end

  // Advance the model on each edge, then compare every DUT output just after the edge.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_phase[i] = 0;
        m_out[i]   = '0;
      end else begin
        case (m_phase[i])
          0: if (in_valid[i]) begin
            m_res[i]  = ref_result(in_op, in_data, in_shamt);
            m_left[i] = ref_lat(i, in_shamt) - 1;
            if (m_left[i] == 0) begin
              m_phase[i] = 2;
              m_out[i]   = m_res[i];
            end else begin
              m_phase[i] = 1;
            end
          end
          1: begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_phase[i] = 2;
              m_out[i]   = m_res[i];
            end
          end
          default: if (out_ready[i]) m_phase[i] = 0;
        endcase
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cyc%0d.out_valid", i), 32'(out_valid[i]), 32'(m_phase[i] == 2));
      check($sformatf("cyc%0d.busy", i), 32'(busy[i]), 32'(m_phase[i] != 0));
      check($sformatf("cyc%0d.in_ready", i), 32'(in_ready[i]), 32'((m_phase[i] == 0) && reset));
      check($sformatf("cyc%0d.out_data", i), out_data[i], m_out[i]);
    end
  end

  task automatic run_op(input int i, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_d, input int exp_lat,
                        input int hold);
    int lat;
    @(negedge clock);
    in_data      = d;
    in_shamt     = s;
    in_op        = op;
    in_valid[i]  = 1'b1;
    out_ready[i] = (hold == 0);
    check("ready_before_accept", 32'(in_ready[i]), 32'd1);
    @(negedge clock);
    in_valid[i] = 1'b0;
    in_data     = $urandom;
    in_shamt    = 5'($urandom);
    in_op       = 2'($urandom);
    lat = 1;
    while (!out_valid[i] && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", out_data[i], exp_d);
    for (int h = 0; h < hold; h++) begin
      in_valid[i] = 1'b1;
      in_data     = $urandom;
      in_shamt    = 5'($urandom);
      @(negedge clock);
      check("hold.out_valid", 32'(out_valid[i]), 32'd1);
      check("hold.out_data", out_data[i], exp_d);
      check("hold.in_ready", 32'(in_ready[i]), 32'd0);
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    @(negedge clock);
    check("consume.out_valid", 32'(out_valid[i]), 32'd0);
    check("consume.in_ready", 32'(in_ready[i]), 32'd1);
    check("consume.out_data_held", out_data[i], exp_d);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    in_data = '0;
    in_shamt = '0;
    in_op = '0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clock);
    check("reset.in_ready0", 32'(in_ready[0]), 32'd0);
    check("reset.out_data0", out_data[0], 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle.in_ready0", 32'(in_ready[0]), 32'd1);
    check("idle.in_ready1", 32'(in_ready[1]), 32'd1);

    // Early exit enabled.
    run_op(0, 2'b00, 32'h0000_0001, 5'd8,  32'h0000_0100, 5, 0);
    run_op(0, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6, 0);
    run_op(0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 6, 0);
    run_op(0, 2'b11, 32'h8000_0001, 5'd4,  32'h0000_0018, 4, 0);
    run_op(0, 2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, 0);
    run_op(0, 2'b10, 32'h8000_0000, 5'd1,  32'hC000_0000, 2, 0);
    run_op(0, 2'b11, 32'h1234_5678, 5'd16, 32'h5678_1234, 6, 3);
    // Early exit disabled: always six edges.
    run_op(1, 2'b00, 32'h0000_0001, 5'd8,  32'h0000_0100, 6, 0);
    run_op(1, 2'b01, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 6, 0);
    run_op(1, 2'b11, 32'h8000_0001, 5'd4,  32'h0000_0018, 6, 0);
    run_op(1, 2'b10, 32'hF000_0000, 5'd16, 32'hFFFF_F000, 6, 3);

    // Reset in the middle of a shift discards the operation.
    @(negedge clock);
    in_data = 32'h8000_0000;
    in_shamt = 5'd31;
    in_op = 2'b01;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clock);
    in_valid[0] = 1'b0;
    @(negedge clock);
    check("mid.busy", 32'(busy[0]), 32'd1);
    check("mid.out_valid", 32'(out_valid[0]), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst.out_valid", 32'(out_valid[0]), 32'd0);
    check("rst.busy", 32'(busy[0]), 32'd0);
    check("rst.out_data", out_data[0], 32'd0);
    check("rst.in_ready", 32'(in_ready[0]), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rel.in_ready", 32'(in_ready[0]), 32'd1);
    repeat (8) @(negedge clock);
    check("rel.no_result", 32'(out_valid[0]), 32'd0);

    // Random operations on both instances.
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] d;
      logic [4:0]  s;
      logic [1:0]  op;
      d  = $urandom;
      s  = 5'($urandom);
      op = 2'($urandom);
      run_op(n % 2, op, d, s, ref_result(op, d, s), ref_lat(n % 2, s), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
